// File: rtl/booth2_seq_mult.sv
// Iterative radix-4 (Booth-2) multiplier: one partial product per clock, valid/ready on both sides.
// Optional macro BOOTH_EARLY_TERM_EN: leave CALC as soon as every remaining Booth digit is zero.
module booth2_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic [1:0]         o_dbg_state
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER);
    localparam int AW   = 2 * WIDTH + 2;
    localparam int MW   = WIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_acc;
    logic [AW-1:0]        r_base;
    logic [AW-1:0]        r_pp;
    logic                 r_neg;
    logic                 r_last;
    logic [MW-1:0]        r_mplier;
    logic [CW-1:0]        r_cnt;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_busy;

    logic [WIDTH+1:0]     w_a_ext;
    logic [1:0]           w_b_sx;
    logic [AW-1:0]        w_acc_sum;
    logic [AW-1:0]        w_pp_sel;
    logic                 w_neg;
    logic [MW-1:0]        w_mplier_next;
    logic                 w_early;
    logic                 w_last_digit;

    assign w_a_ext = {{2{signed_mode & a[WIDTH-1]}}, a};
    assign w_b_sx  = {2{signed_mode & b[WIDTH-1]}};

    // Subtraction is the inverted partial product plus a carry-in of r_neg.
    assign w_acc_sum = r_acc + (r_pp ^ {AW{r_neg}}) + {{(AW-1){1'b0}}, r_neg};

    always_comb begin
        w_pp_sel = '0;
        w_neg    = 1'b0;
        case (r_mplier[2:0])
            3'b001, 3'b010: w_pp_sel = r_base;
            3'b011:         w_pp_sel = r_base << 1;
            3'b100: begin
                w_pp_sel = r_base << 1;
                w_neg    = 1'b1;
            end
            3'b101, 3'b110: begin
                w_pp_sel = r_base;
                w_neg    = 1'b1;
            end
            default: begin
                w_pp_sel = '0;
                w_neg    = 1'b0;
            end
        endcase
    end

    // Shift in copies of the top bit so the vacated positions never break uniformity.
    assign w_mplier_next = {{2{r_mplier[MW-1]}}, r_mplier[MW-1:2]};

`ifdef BOOTH_EARLY_TERM_EN
    assign w_early = (&w_mplier_next) | (~|w_mplier_next);
`else
    assign w_early = 1'b0;
`endif

    assign w_last_digit = (r_cnt == CW'(ITER - 1)) | w_early;

    // Selection of digit i and its accumulation are one cycle apart, hence the r_last drain cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_base      <= '0;
            r_pp        <= '0;
            r_neg       <= 1'b0;
            r_last      <= 1'b0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_base   <= {{WIDTH{w_a_ext[WIDTH+1]}}, w_a_ext};
                        r_mplier <= {w_b_sx, b, 1'b0};
                        r_acc    <= '0;
                        r_pp     <= '0;
                        r_neg    <= 1'b0;
                        r_last   <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_sum;
                    if (r_last) begin
                        r_product   <= w_acc_sum[2*WIDTH-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_pp     <= w_pp_sel;
                        r_neg    <= w_neg;
                        r_mplier <= w_mplier_next;
                        r_base   <= r_base << 2;
                        if (w_last_digit) begin
                            r_last <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE) && !rst;
    assign out_valid   = r_out_valid;
    assign product     = r_product;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_booth2_seq_mult.sv
// Directed and random checks of booth2_seq_mult at WIDTH=8 and WIDTH=16 against a behavioural product.
module tb_booth2_seq_mult;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, signed_mode, out_ready;
    logic [7:0]  a, b;
    logic        in_ready, out_valid, busy;
    logic [15:0] product;
    logic [1:0]  dbg_state;

    logic        in_valid16, signed_mode16, out_ready16;
    logic [15:0] a16, b16;
    logic        in_ready16, out_valid16, busy16;
    logic [31:0] product16;
    logic [1:0]  dbg_state16;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] exp_q[$];
    logic [31:0] exp16_q[$];

`ifdef BOOTH_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    booth2_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy), .o_dbg_state(dbg_state)
    );

    booth2_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .signed_mode(signed_mode16), .a(a16), .b(b16), .out_valid(out_valid16),
        .out_ready(out_ready16), .product(product16), .busy(busy16), .o_dbg_state(dbg_state16)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref8(input logic sm, input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] sx, sy;
        sx = {{8{x[7]}}, x};
        sy = {{8{y[7]}}, y};
        if (sm) return 16'(sx * sy);
        return {8'h00, x} * {8'h00, y};
    endfunction

    function automatic logic [31:0] ref16(input logic sm, input logic [15:0] x, input logic [15:0] y);
        logic signed [31:0] sx, sy;
        sx = {{16{x[15]}}, x};
        sy = {{16{y[15]}}, y};
        if (sm) return 32'(sx * sy);
        return {16'h0000, x} * {16'h0000, y};
    endfunction

    // Returns on the falling edge right after the accepting rising edge.
    task automatic send8(input logic sm, input logic [7:0] x, input logic [7:0] y);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        signed_mode = sm;
        a           = x;
        b           = y;
        in_valid    = 1'b1;
        exp_q.push_back(ref8(sm, x, y));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid8(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic collect8(input string tag, output int lat);
        logic [15:0] e;
        wait_valid8(lat);
        e = exp_q.pop_front();
        if (!out_valid) begin
            check({tag, "_timeout"}, out_valid, 1);
        end else begin
            check(tag, product, e);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic send16(input logic sm, input logic [15:0] x, input logic [15:0] y);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready16 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready16) check("in_ready16_timeout", in_ready16, 1);
        signed_mode16 = sm;
        a16           = x;
        b16           = y;
        in_valid16    = 1'b1;
        exp16_q.push_back(ref16(sm, x, y));
        @(negedge clk);
        in_valid16 = 1'b0;
    endtask

    task automatic collect16(input string tag, output int lat);
        logic [31:0] e;
        lat = 0;
        while (!out_valid16 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = exp16_q.pop_front();
        if (!out_valid16) begin
            check({tag, "_timeout"}, out_valid16, 1);
        end else begin
            check(tag, product16, e);
            out_ready16 = 1'b1;
            @(negedge clk);
            out_ready16 = 1'b0;
        end
    endtask

    initial begin
        int lat;
        bit rose;
        logic sm;
        logic [7:0] x, y;
        logic [15:0] x16, y16;

        rst = 1'b1;
        in_valid = 1'b0; signed_mode = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        in_valid16 = 1'b0; signed_mode16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b0;

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("in_ready_in_rst", in_ready, 0);
        check("in_ready16_in_rst", in_ready16, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);

        // Directed products and latency
        send8(1'b1, 8'h80, 8'h80);
        check("busy_calc", busy, 1);
        check("in_ready_calc", in_ready, 0);
        collect8("s_min_x_min", lat);
        check("lat_min_x_min", lat, EARLY ? 5 : 6);
        send8(1'b1, 8'hFF, 8'hFF);
        collect8("s_m1_x_m1", lat);
        check("lat_s_ff", lat, EARLY ? 2 : 6);
        send8(1'b0, 8'hFF, 8'hFF);
        collect8("u_max_x_max", lat);
        check("lat_u_ff", lat, 6);
        send8(1'b0, 8'h00, 8'hFF);
        collect8("u_zero_x_max", lat);
        check("after_done_in_ready", in_ready, 1);
        check("after_done_busy", busy, 0);
`ifdef BOOTH_EARLY_TERM_EN
        send8(1'b0, 8'h5A, 8'h00);
        collect8("et_b_zero", lat);
        check("et_lat_b_zero", lat, 2);
        send8(1'b1, 8'h5A, 8'h03);
        collect8("et_b_three", lat);
        check("et_lat_b_three", lat, 3);
`endif

        // Backpressure: hold product, ignore new operands
        send8(1'b1, 8'h12, 8'h34);
        wait_valid8(lat);
        check("bp_valid_rise", out_valid, 1);
        a = 8'h77; b = 8'h77; signed_mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_product", product, exp_q[0]);
            check("bp_in_ready", in_ready, 0);
            check("bp_state", dbg_state, 2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_state", dbg_state, 0);
        send8(1'b0, 8'h0D, 8'h0B);
        collect8("bp_next_op", lat);

        // Reset in the middle of an operation
        send8(1'b1, 8'h55, 8'h66);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("midrst_state", dbg_state, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        check("midrst_no_out_valid", rose, 0);
        send8(1'b1, 8'h07, 8'hFD);
        collect8("midrst_7_x_m3", lat);

        // Random WIDTH=8
        for (int i = 0; i < 1500; i++) begin
            sm = 1'($urandom_range(0, 1));
            x  = 8'($urandom_range(0, 255));
            y  = 8'($urandom_range(0, 255));
            send8(sm, x, y);
            collect8("rand8", lat);
            if (!EARLY) check("rand8_lat", lat, 6);
        end

        // Random WIDTH=16, including the boundary corners
        send16(1'b1, 16'h8000, 16'h8000);
        collect16("s16_min_x_min", lat);
        send16(1'b0, 16'hFFFF, 16'hFFFF);
        collect16("u16_max_x_max", lat);
        if (!EARLY) check("lat16", lat, 10);
        for (int i = 0; i < 800; i++) begin
            sm  = 1'($urandom_range(0, 1));
            x16 = 16'($urandom_range(0, 65535));
            y16 = 16'($urandom_range(0, 65535));
            send16(sm, x16, y16);
            collect16("rand16", lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
